iic_opr: RTL and testbench

IIC_OPR -- requirements
Module: iic_opr

---
 rtl/iic_opr.sv | 192 +++++++++++++++++++
 tb/tb_iic_opr.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_opr.sv
// Write-only I2C master: sends sendBytes bytes (MSB first) per transaction from a valid/ready
// byte stream, with quarter-period bus timing and registered SCL/SDA.
module iic_opr #(
   parameter int unsigned QUARTER = 125
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] sendBytes,
   input  logic       tvalid,
   input  logic [7:0] tdata,
   output logic       tready,
   output logic       SCL,
   inout  wire        SDA,
   output logic       done,
   output logic       ack_err
);

   localparam int unsigned CntW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(QUARTER - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] BIT       = 3'd2;
   localparam logic [2:0] ACK       = 3'd3;
   localparam logic [2:0] WAIT_DATA = 3'd4;
   localparam logic [2:0] STOP      = 3'd5;

   logic [2:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      phase_q, phase_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [7:0]      rem_q, rem_d;
   logic            ack_err_q, ack_err_d;
   logic            done_q, done_d;
   logic            scl_q, scl_d;
   logic            sda_low_q, sda_low_d;
   logic            tready_q, tready_d;
   logic            tick;
   logic            accept;

   assign tick   = (cnt_q == CntMax);
   assign accept = tvalid & tready_q;

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      rem_d     = rem_q;
      ack_err_d = ack_err_q;
      done_d    = 1'b0;
      cnt_d     = tick ? '0 : cnt_q + CntW'(1);

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               shreg_d   = tdata;
               rem_d     = (sendBytes == 8'd0) ? 8'd1 : sendBytes;
               ack_err_d = 1'b0;
               state_d   = START;
               phase_d   = 2'd0;
            end
         end
         START: begin
            if (tick) begin
               if (phase_q == 2'd1) begin
                  state_d = BIT;
                  phase_d = 2'd0;
                  bit_d   = 3'd0;
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end
         end
         BIT: begin
            if (tick) begin
               if (phase_q == 2'd3) begin
                  phase_d = 2'd0;
                  shreg_d = {shreg_q[6:0], 1'b0};
                  if (bit_q == 3'd7) state_d = ACK;
                  else               bit_d   = bit_q + 3'd1;
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end
         end
         ACK: begin
            if (tick) begin
               // Anything but a solid 0 (high, Z or X) counts as NACK.
               if (phase_q == 2'd1) begin
                  ack_err_d = 1'b1;
                  if (SDA == 1'b0) ack_err_d = ack_err_q;
               end
               if (phase_q == 2'd3) begin
                  phase_d = 2'd0;
                  rem_d   = rem_q - 8'd1;
                  state_d = (rem_q != 8'd1) ? WAIT_DATA : STOP;
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end
         end
         WAIT_DATA: begin
            cnt_d = '0;
            if (accept) begin
               shreg_d = tdata;
               state_d = BIT;
               phase_d = 2'd0;
               bit_d   = 3'd0;
            end
         end
         STOP: begin
            if (tick) begin
               if (phase_q == 2'd2) begin
                  state_d = IDLE;
                  phase_d = 2'd0;
                  done_d  = 1'b1;
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus pins are decoded from the next state so they change on the same edge as the state.
   always_comb begin
      scl_d     = 1'b1;
      sda_low_d = 1'b0;
      tready_d  = 1'b0;
      case (state_d)
         IDLE:      tready_d = 1'b1;
         START: begin
            scl_d     = (phase_d == 2'd0);
            sda_low_d = 1'b1;
         end
         BIT: begin
            scl_d     = (phase_d == 2'd1) || (phase_d == 2'd2);
            sda_low_d = ~shreg_d[7];
         end
         ACK:       scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
         WAIT_DATA: begin
            scl_d     = 1'b0;
            sda_low_d = 1'b1;
            tready_d  = 1'b1;
         end
         STOP: begin
            scl_d     = (phase_d != 2'd0);
            sda_low_d = (phase_d != 2'd2);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         phase_q   <= 2'd0;
         bit_q     <= 3'd0;
         shreg_q   <= 8'd0;
         rem_q     <= 8'd0;
         ack_err_q <= 1'b0;
         done_q    <= 1'b0;
         scl_q     <= 1'b1;
         sda_low_q <= 1'b0;
         tready_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         rem_q     <= rem_d;
         ack_err_q <= ack_err_d;
         done_q    <= done_d;
         scl_q     <= scl_d;
         sda_low_q <= sda_low_d;
         tready_q  <= tready_d;
      end
   end

   assign SDA     = sda_low_q ? 1'b0 : 1'bz;
   assign SCL     = scl_q;
   assign tready  = tready_q;
   assign done    = done_q;
   assign ack_err = ack_err_q;

endmodule

// File: tb/tb_iic_opr.sv
// Bench for iic_opr: bus-level monitor decodes START/STOP/bits on the wire, an optional slave
// drives ACK, and each transaction is compared against the bytes the bench sent.
module tb_iic_opr;

   localparam int unsigned QUARTER = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] send_bytes = 8'd0;
   logic       tvalid = 1'b0;
   logic [7:0] tdata = 8'd0;
   wire        tready;
   wire        scl;
   wire        sda;
   wire        done;
   wire        ack_err;

   logic       slave_low = 1'b0;
   logic       slave_en = 1'b0;

   pullup (sda);
   assign sda = slave_low ? 1'b0 : 1'bz;

   iic_opr #(.QUARTER(QUARTER)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .sendBytes (send_bytes),
      .tvalid    (tvalid),
      .tdata     (tdata),
      .tready    (tready),
      .SCL       (scl),
      .SDA       (sda),
      .done      (done),
      .ack_err   (ack_err)
   );

   always #5 clk = ~clk;

   // Bus monitor and ACK-driving slave, sampled on the falling edge.
   int         pulses = 0, starts = 0, stops = 0, done_cnt = 0, hs_cnt = 0, rib = 0;
   logic       pending = 1'b0, rise_bit = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1;
   logic [7:0] acc_q[$];
   logic       bits_q[$];

   always @(negedge clk) begin
      if (!resetn) begin
         pending   <= 1'b0;
         rib       <= 0;
         slave_low <= 1'b0;
      end else begin
         if (tvalid && tready) begin
            hs_cnt <= hs_cnt + 1;
            acc_q.push_back(tdata);
         end
         if (done) done_cnt <= done_cnt + 1;
         if (scl && !prev_scl) begin
            pending  <= 1'b1;
            rise_bit <= sda;
         end
         if (!scl && prev_scl && pending) begin
            pending <= 1'b0;
            pulses  <= pulses + 1;
            bits_q.push_back(rise_bit);
            if (rib == 7) begin
               slave_low <= slave_en;
               rib       <= 8;
            end else if (rib == 8) begin
               slave_low <= 1'b0;
               rib       <= 0;
            end else begin
               rib <= rib + 1;
            end
         end
         if (scl && prev_scl && !sda && prev_sda) begin
            starts <= starts + 1;
            rib    <= 0;
         end
         if (scl && prev_scl && sda && !prev_sda) begin
            stops   <= stops + 1;
            pending <= 1'b0;
         end
      end
      prev_scl <= scl;
      prev_sda <= sda;
   end

   int         tests = 0;
   int         fails = 0;
   logic [7:0] tx_bytes[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the bits seen on the wire for nb bytes starting at queue offsets b_bits/b_acc.
   task automatic check_bytes(input string tag, input int nb, input int b_bits, input int b_acc,
                              input logic ack_bit);
      logic [8:0] got;
      check({tag, " bit_count"}, bits_q.size() - b_bits, 9 * nb);
      check({tag, " accept_count"}, acc_q.size() - b_acc, nb);
      if (bits_q.size() >= b_bits + 9 * nb && acc_q.size() >= b_acc + nb) begin
         for (int j = 0; j < nb; j++) begin
            got = '0;
            for (int k = 0; k < 9; k++) got = {got[7:0], bits_q[b_bits + 9 * j + k]};
            check($sformatf("%s byte%0d_wire", tag, j), {23'd0, got}, {23'd0, tx_bytes[j], ack_bit});
            check($sformatf("%s byte%0d_accepted", tag, j), {24'd0, acc_q[b_acc + j]},
                  {24'd0, tx_bytes[j]});
         end
      end
   endtask

   task automatic run_txn(input string tag, input logic [7:0] sb, input logic ack_on,
                          input int gap);
      int nb, waited, bad;
      int b_pulses, b_starts, b_stops, b_done, b_hs, b_bits, b_acc;
      nb       = (sb == 8'd0) ? 1 : int'(sb);
      b_pulses = pulses;
      b_starts = starts;
      b_stops  = stops;
      b_done   = done_cnt;
      b_hs     = hs_cnt;
      b_bits   = bits_q.size();
      b_acc    = acc_q.size();
      slave_en   = ack_on;
      send_bytes = sb;
      for (int i = 0; i < nb; i++) begin
         if (i > 0 && gap > 0) begin
            tvalid = 1'b0;
            waited = 0;
            while (tready !== 1'b1 && waited < 2000) begin
               tick();
               waited++;
            end
            bad = 0;
            for (int k = 0; k < gap; k++) begin
               if (!(tready === 1'b1 && scl === 1'b0 && sda === 1'b0)) bad++;
               tick();
            end
            check({tag, " wait_hold_bad_cycles"}, bad, 0);
         end
         tdata  = tx_bytes[i];
         tvalid = 1'b1;
         waited = 0;
         while (tready !== 1'b1 && waited < 2000) begin
            tick();
            waited++;
         end
         tick();
         tvalid = 1'b0;
         tdata  = 8'($urandom);
      end
      waited = 0;
      while (done !== 1'b1 && waited < 3000) begin
         tick();
         waited++;
      end
      check({tag, " done_seen"}, {31'd0, done}, 1);
      check({tag, " ack_err"}, {31'd0, ack_err}, ack_on ? 0 : 1);
      repeat (4) tick();
      check({tag, " scl_pulses"}, pulses - b_pulses, 9 * nb);
      check({tag, " starts"}, starts - b_starts, 1);
      check({tag, " stops"}, stops - b_stops, 1);
      check({tag, " done_pulses"}, done_cnt - b_done, 1);
      check({tag, " handshakes"}, hs_cnt - b_hs, nb);
      check_bytes(tag, nb, b_bits, b_acc, ~ack_on);
   endtask

   initial begin
      int         waited, seen, b_pulses, b_starts, b_stops, b_done, b_hs, b_bits, b_acc;
      logic [7:0] sb;

      // Reset state
      resetn = 1'b0;
      repeat (3) tick();
      check("rst scl", {31'd0, scl}, 1);
      check("rst sda", {31'd0, sda}, 1);
      check("rst tready", {31'd0, tready}, 0);
      check("rst done", {31'd0, done}, 0);
      check("rst ack_err", {31'd0, ack_err}, 0);
      resetn = 1'b1;
      tick();
      check("post_rst tready", {31'd0, tready}, 1);
      check("post_rst scl", {31'd0, scl}, 1);

      // Single byte, no slave
      tx_bytes = '{8'hA7};
      run_txn("a7_nack", 8'd1, 1'b0, 0);

      // Three bytes with slave ACK
      tx_bytes = '{8'hA7, 8'hA8, 8'hA9};
      run_txn("three_ack", 8'd3, 1'b1, 0);

      // Two bytes with a 50-cycle stall before byte 2
      tx_bytes = '{8'($urandom), 8'($urandom)};
      run_txn("stall50", 8'd2, 1'b1, 50);

      // sendBytes=0 acts as one byte
      tx_bytes = '{8'($urandom)};
      run_txn("zero_len", 8'd0, 1'b0, 0);

      // Randomized transactions
      for (int t = 0; t < 4; t++) begin
         tx_bytes = '{8'($urandom), 8'($urandom), 8'($urandom)};
         sb = 8'($urandom_range(0, 3));
         run_txn($sformatf("rand%0d", t), sb, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : 0);
      end

      // Back-to-back transactions with tvalid held high
      tx_bytes   = '{8'($urandom), 8'($urandom)};
      tx_bytes[1] = tx_bytes[0];
      b_pulses   = pulses;
      b_starts   = starts;
      b_stops    = stops;
      b_done     = done_cnt;
      b_hs       = hs_cnt;
      b_bits     = bits_q.size();
      b_acc      = acc_q.size();
      slave_en   = 1'b0;
      send_bytes = 8'd1;
      tdata      = tx_bytes[0];
      tvalid     = 1'b1;
      seen       = 0;
      waited     = 0;
      while (seen < 2 && waited < 4000) begin
         tick();
         waited++;
         if (done === 1'b1) seen++;
      end
      tvalid = 1'b0;
      check("b2b done_seen", seen, 2);
      repeat (4) tick();
      check("b2b scl_pulses", pulses - b_pulses, 18);
      check("b2b starts", starts - b_starts, 2);
      check("b2b stops", stops - b_stops, 2);
      check("b2b done_pulses", done_cnt - b_done, 2);
      check("b2b handshakes", hs_cnt - b_hs, 2);
      check_bytes("b2b", 2, b_bits, b_acc, 1'b1);

      // Reset during bit 4
      tx_bytes   = '{8'($urandom)};
      send_bytes = 8'd1;
      slave_en   = 1'b0;
      b_pulses   = pulses;
      tdata      = tx_bytes[0];
      tvalid     = 1'b1;
      waited     = 0;
      while (tready !== 1'b1 && waited < 100) begin
         tick();
         waited++;
      end
      tick();
      tvalid = 1'b0;
      waited = 0;
      while (pulses - b_pulses < 4 && waited < 2000) begin
         tick();
         waited++;
      end
      waited = 0;
      while (scl !== 1'b1 && waited < 100) begin
         tick();
         waited++;
      end
      check("midrst reached_bit4", pulses - b_pulses, 4);
      resetn = 1'b0;
      tick();
      check("midrst scl", {31'd0, scl}, 1);
      check("midrst sda", {31'd0, sda}, 1);
      check("midrst tready", {31'd0, tready}, 0);
      check("midrst done", {31'd0, done}, 0);
      repeat (2) tick();
      b_done = done_cnt;
      resetn = 1'b1;
      tick();
      check("midrst post tready", {31'd0, tready}, 1);
      repeat (20) tick();
      check("midrst no_done", done_cnt - b_done, 0);
      check("midrst idle scl", {31'd0, scl}, 1);
      check("midrst idle sda", {31'd0, sda}, 1);
      check("midrst idle tready", {31'd0, tready}, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
